// File: rtl/conv_pkg.sv
// Shared types and frame-geometry helpers for the conv2d front-end sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int n_pix(input int n_image);
    return n_image * n_image;
  endfunction

  function automatic int n_win(input int n_image, input int k_kernel);
    return (n_image - k_kernel + 1) * (n_image - k_kernel + 1);
  endfunction

endpackage

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: clears the window buffer, streams one raster-order frame from
// the image RAM into it, counts emitted windows and flags a short/long frame.
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int N_IMAGE       = 8,
  parameter int K_KERNEL      = 3,
  parameter int BWD           = 8,
  parameter int DRAIN_TIMEOUT = 8
) (
  input  logic                                          clk,
  input  logic                                          clear,
  input  logic                                          i_start,
  input  logic                                          i_stall,
  output logic                                          o_mem_rd,
  output logic [$clog2(N_IMAGE*N_IMAGE)-1:0]            o_mem_addr,
  input  logic [BWD-1:0]                                i_mem_data,
  output logic                                          o_wb_clear,
  output logic [BWD-1:0]                                o_wb_data,
  output logic                                          o_wb_valid,
  input  logic                                          i_wb_window_valid,
  input  logic                                          i_wb_window_end,
  output logic                                          o_busy,
  output logic                                          o_done,
  output logic                                          o_error,
  output logic [$clog2((N_IMAGE-K_KERNEL+1)**2+1)-1:0]  o_win_cnt
);

  localparam int N_PIX = n_pix(N_IMAGE);
  localparam int N_WIN = n_win(N_IMAGE, K_KERNEL);
  localparam int AW    = $clog2(N_IMAGE*N_IMAGE);
  localparam int CW    = $clog2((N_IMAGE-K_KERNEL+1)**2+1);
  localparam int TW    = $clog2(DRAIN_TIMEOUT+1);

  state_t          state_reg;
  logic [AW-1:0]   addr_reg;
  logic [CW-1:0]   cnt_reg;
  logic [TW-1:0]   tmo_reg;
  logic            end_seen_reg;
  logic            error_reg;
  logic            done_reg;
  logic            rd_d_reg;

  logic            counting;
  logic            end_now;
  logic [CW:0]     final_cnt;
  logic            cnt_bad;

  assign counting   = (state_reg == FEED) || (state_reg == DRAIN);
  assign end_now    = counting && i_wb_window_end;
  // The closing window may arrive together with the end flag, so include it.
  assign final_cnt  = {1'b0, cnt_reg} + (CW+1)'(i_wb_window_valid);
  assign cnt_bad    = final_cnt != (CW+1)'(N_WIN);

  assign o_mem_rd   = (state_reg == FEED) && !i_stall;
  assign o_mem_addr = addr_reg;
  assign o_wb_clear = clear || (state_reg == CLR);
  assign o_wb_data  = i_mem_data;
  assign o_wb_valid = rd_d_reg;
  assign o_busy     = state_reg != IDLE;
  assign o_done     = done_reg;
  assign o_error    = error_reg;
  assign o_win_cnt  = cnt_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      tmo_reg      <= '0;
      end_seen_reg <= 1'b0;
      error_reg    <= 1'b0;
      done_reg     <= 1'b0;
      rd_d_reg     <= 1'b0;
    end else begin
      rd_d_reg <= o_mem_rd;
      done_reg <= 1'b0;

      if (counting && i_wb_window_valid && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (end_now && cnt_bad) begin
        error_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (i_start) begin
            state_reg <= CLR;
          end
        end
        CLR: begin
          addr_reg     <= '0;
          cnt_reg      <= '0;
          tmo_reg      <= '0;
          end_seen_reg <= 1'b0;
          error_reg    <= 1'b0;
          state_reg    <= FEED;
        end
        FEED: begin
          if (end_now) begin
            end_seen_reg <= 1'b1;
          end
          if (o_mem_rd) begin
            // Last address is held rather than wrapped; the state change ends the reads.
            if (addr_reg == AW'(N_PIX-1)) begin
              tmo_reg   <= '0;
              state_reg <= DRAIN;
            end else begin
              addr_reg <= addr_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          tmo_reg <= tmo_reg + 1'b1;
          if (end_now || end_seen_reg) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else if (tmo_reg == TW'(DRAIN_TIMEOUT-1)) begin
            error_reg <= 1'b1;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl with a behavioural image RAM and a
// window-buffer model that can drop a window or suppress the end flag.
module tb_conv_frame_ctrl;

  localparam int N    = 8;
  localparam int K    = 3;
  localparam int BWD  = 8;
  localparam int DT   = 8;
  localparam int AW   = 6;
  localparam int CW   = 6;

  logic            clk = 1'b0;
  logic            clear;
  logic            i_start;
  logic            i_stall;
  logic            o_mem_rd;
  logic [AW-1:0]   o_mem_addr;
  logic [BWD-1:0]  i_mem_data;
  logic            o_wb_clear;
  logic [BWD-1:0]  o_wb_data;
  logic            o_wb_valid;
  logic            i_wb_window_valid;
  logic            i_wb_window_end;
  logic            o_busy;
  logic            o_done;
  logic            o_error;
  logic [CW-1:0]   o_win_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_frame_ctrl #(
    .N_IMAGE(N), .K_KERNEL(K), .BWD(BWD), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .clear(clear), .i_start(i_start), .i_stall(i_stall),
    .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_wb_clear(o_wb_clear), .o_wb_data(o_wb_data), .o_wb_valid(o_wb_valid),
    .i_wb_window_valid(i_wb_window_valid), .i_wb_window_end(i_wb_window_end),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_win_cnt(o_win_cnt)
  );

  // Image RAM: pixel i holds i*7+3, one-cycle read latency.
  logic [BWD-1:0] mem [64];
  always @(posedge clk) begin
    if (o_mem_rd) i_mem_data <= mem[o_mem_addr];
  end

  // Window buffer model: a KxK window completes on every pixel with row,col >= K-1.
  bit drop_win = 1'b0;
  bit kill_end = 1'b0;
  int wb_pcnt;
  always @(posedge clk) begin
    if (o_wb_clear) begin
      wb_pcnt           <= 0;
      i_wb_window_valid <= 1'b0;
      i_wb_window_end   <= 1'b0;
    end else if (o_wb_valid) begin
      i_wb_window_valid <= (wb_pcnt / N >= K-1) && (wb_pcnt % N >= K-1) && !(drop_win && wb_pcnt == 30);
      i_wb_window_end   <= (wb_pcnt == N*N-1) && !kill_end;
      wb_pcnt           <= wb_pcnt + 1;
    end else begin
      i_wb_window_valid <= 1'b0;
      i_wb_window_end   <= 1'b0;
    end
  end

  // Per-frame capture filled by run_frame.
  int            cap_clr, cap_rd, cap_pix, cap_done;
  int            cap_first_rd_cyc, cap_last_rd_cyc, cap_done_cyc;
  bit            cap_addr_ok, cap_pix_ok, cap_err_done, cap_err_feed, cap_busy_after, cap_timeout;
  logic [CW-1:0] cap_win;

  task automatic run_frame(input int stall_pct, input bit hold_start);
    int  exp_addr = 0;
    int  exp_pix  = 0;
    bit  first_rd = 1'b1;
    bit  done_seen = 1'b0;
    bit  fin = 1'b0;
    cap_clr = 0; cap_rd = 0; cap_pix = 0; cap_done = 0;
    cap_first_rd_cyc = -1; cap_last_rd_cyc = -1; cap_done_cyc = -1;
    cap_addr_ok = 1'b1; cap_pix_ok = 1'b1; cap_err_done = 1'b0; cap_err_feed = 1'b1;
    cap_busy_after = 1'b1; cap_win = '0;
    for (int c = 0; c < 600 && !fin; c++) begin
      @(negedge clk);
      i_start = (c == 0) || (hold_start && !done_seen);
      i_stall = (c > 0 && stall_pct > 0) ? ($urandom_range(99) < stall_pct) : 1'b0;
      #1;
      if (o_wb_clear) cap_clr++;
      if (o_mem_rd) begin
        if (first_rd) begin
          cap_err_feed     = o_error;
          cap_first_rd_cyc = c;
        end
        first_rd = 1'b0;
        if (o_mem_addr != AW'(exp_addr)) cap_addr_ok = 1'b0;
        if (o_mem_addr == AW'(N*N-1)) cap_last_rd_cyc = c;
        exp_addr++;
        cap_rd++;
      end
      if (o_wb_valid) begin
        if (o_wb_data != 8'(exp_pix*7+3)) cap_pix_ok = 1'b0;
        exp_pix++;
        cap_pix++;
      end
      if (done_seen) begin
        cap_busy_after = o_busy;
        cap_win        = o_win_cnt;
        fin            = 1'b1;
      end else if (o_done) begin
        cap_done++;
        cap_done_cyc = c;
        cap_err_done = o_error;
        done_seen    = 1'b1;
      end
    end
    i_start = 1'b0;
    i_stall = 1'b0;
    cap_timeout = !fin;
    $display("frame: stall=%0d%% reads=%0d pixels=%0d windows=%0d done=%0d error=%0d",
             stall_pct, cap_rd, cap_pix, cap_win, cap_done, cap_err_done);
  endtask

  task automatic test_reset();
    clear = 1'b1; i_start = 1'b0; i_stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (o_wb_clear !== 1'b1) begin n_fail++; $display("FAIL reset_wb_clear: got %0b, expected 1", o_wb_clear); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, expected 0", o_busy); end
    n_checks++; if (o_mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %0b, expected 0", o_mem_rd); end
    n_checks++; if (o_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %0b, expected 0", o_wb_valid); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b, expected 0", o_done); end
    n_checks++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %0b, expected 0", o_error); end
    n_checks++; if (o_win_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_win_cnt: got %0d, expected 0", o_win_cnt); end
    @(negedge clk);
    clear = 1'b0;
    #1;
    n_checks++; if (o_wb_clear !== 1'b0) begin n_fail++; $display("FAIL idle_wb_clear: got %0b, expected 0", o_wb_clear); end
  endtask

  task automatic test_nominal();
    run_frame(0, 1'b0);
    n_checks++; if (cap_timeout) begin n_fail++; $display("FAIL nominal_timeout: got no done, expected done"); end
    n_checks++; if (cap_clr != 1) begin n_fail++; $display("FAIL nominal_wb_clear: got %0d cycles, expected 1", cap_clr); end
    n_checks++; if (cap_rd != 64 || !cap_addr_ok) begin n_fail++; $display("FAIL nominal_reads: got %0d (order ok=%0b), expected 64 in order", cap_rd, cap_addr_ok); end
    n_checks++; if (cap_first_rd_cyc != 2 || cap_last_rd_cyc != 65) begin n_fail++; $display("FAIL nominal_read_span: got %0d..%0d, expected 2..65", cap_first_rd_cyc, cap_last_rd_cyc); end
    n_checks++; if (cap_pix != 64 || !cap_pix_ok) begin n_fail++; $display("FAIL nominal_pixels: got %0d (data ok=%0b), expected 64 matching", cap_pix, cap_pix_ok); end
    n_checks++; if (cap_win !== 6'd36) begin n_fail++; $display("FAIL nominal_win_cnt: got %0d, expected 36", cap_win); end
    n_checks++; if (cap_done != 1 || cap_done_cyc != 68) begin n_fail++; $display("FAIL nominal_done: got %0d at cycle %0d, expected 1 at 68", cap_done, cap_done_cyc); end
    n_checks++; if (cap_err_done !== 1'b0) begin n_fail++; $display("FAIL nominal_error: got %0b, expected 0", cap_err_done); end
    n_checks++; if (cap_busy_after !== 1'b0) begin n_fail++; $display("FAIL nominal_busy_after: got %0b, expected 0", cap_busy_after); end
  endtask

  task automatic test_stall();
    run_frame(30, 1'b0);
    n_checks++; if (cap_timeout) begin n_fail++; $display("FAIL stall_timeout: got no done, expected done"); end
    n_checks++; if (cap_rd != 64 || !cap_addr_ok) begin n_fail++; $display("FAIL stall_reads: got %0d (order ok=%0b), expected 64 in order", cap_rd, cap_addr_ok); end
    n_checks++; if (cap_pix != 64 || !cap_pix_ok) begin n_fail++; $display("FAIL stall_pixels: got %0d (data ok=%0b), expected 64 matching", cap_pix, cap_pix_ok); end
    n_checks++; if (cap_win !== 6'd36) begin n_fail++; $display("FAIL stall_win_cnt: got %0d, expected 36", cap_win); end
    n_checks++; if (cap_done != 1 || cap_err_done !== 1'b0) begin n_fail++; $display("FAIL stall_done: got done=%0d error=%0b, expected done=1 error=0", cap_done, cap_err_done); end
  endtask

  task automatic test_hold_start();
    int busy_cycles = 0;
    run_frame(0, 1'b1);
    n_checks++; if (cap_clr != 1) begin n_fail++; $display("FAIL hold_wb_clear: got %0d cycles, expected 1", cap_clr); end
    n_checks++; if (cap_rd != 64 || cap_done != 1) begin n_fail++; $display("FAIL hold_frame: got reads=%0d done=%0d, expected 64 and 1", cap_rd, cap_done); end
    n_checks++; if (cap_busy_after !== 1'b0) begin n_fail++; $display("FAIL hold_idle_gap: got busy=%0b, expected 0", cap_busy_after); end
    repeat (3) begin
      @(negedge clk); #1;
      if (o_busy) busy_cycles++;
    end
    n_checks++; if (busy_cycles != 0) begin n_fail++; $display("FAIL hold_no_restart: got %0d busy cycles, expected 0", busy_cycles); end
  endtask

  task automatic test_drain_timeout();
    kill_end = 1'b1;
    run_frame(0, 1'b0);
    kill_end = 1'b0;
    n_checks++; if (cap_done != 1) begin n_fail++; $display("FAIL timeout_done: got %0d, expected 1", cap_done); end
    n_checks++; if (cap_err_done !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %0b, expected 1", cap_err_done); end
    n_checks++; if (cap_done_cyc - (cap_last_rd_cyc + 1) != DT) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles, expected %0d", cap_done_cyc - (cap_last_rd_cyc + 1), DT); end
    n_checks++; if (o_error !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %0b, expected 1", o_error); end
    run_frame(0, 1'b0);
    n_checks++; if (cap_err_feed !== 1'b0) begin n_fail++; $display("FAIL restart_error_cleared: got %0b, expected 0", cap_err_feed); end
    n_checks++; if (cap_err_done !== 1'b0 || cap_done != 1) begin n_fail++; $display("FAIL restart_done: got done=%0d error=%0b, expected done=1 error=0", cap_done, cap_err_done); end
  endtask

  task automatic test_dropped_window();
    drop_win = 1'b1;
    run_frame(0, 1'b0);
    drop_win = 1'b0;
    n_checks++; if (cap_win !== 6'd35) begin n_fail++; $display("FAIL drop_win_cnt: got %0d, expected 35", cap_win); end
    n_checks++; if (cap_err_done !== 1'b1) begin n_fail++; $display("FAIL drop_error: got %0b, expected 1", cap_err_done); end
    n_checks++; if (cap_done != 1) begin n_fail++; $display("FAIL drop_done: got %0d, expected 1", cap_done); end
  endtask

  task automatic test_clear_mid_frame();
    bit hit = 1'b0;
    int dones = 0;
    @(negedge clk);
    i_start = 1'b1; i_stall = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      #1;
      if (o_mem_rd && o_mem_addr == 6'd20) hit = 1'b1;
    end
    n_checks++; if (!hit) begin n_fail++; $display("FAIL abort_reach_pixel20: got no read at 20, expected one"); end
    @(negedge clk);
    clear = 1'b1;
    #1;
    n_checks++; if (o_wb_clear !== 1'b1) begin n_fail++; $display("FAIL abort_wb_clear: got %0b, expected 1", o_wb_clear); end
    @(negedge clk);
    clear = 1'b0;
    #1;
    n_checks++; if (o_mem_rd !== 1'b0) begin n_fail++; $display("FAIL abort_mem_rd: got %0b, expected 0", o_mem_rd); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b, expected 0", o_busy); end
    n_checks++; if (o_win_cnt !== 6'd0) begin n_fail++; $display("FAIL abort_win_cnt: got %0d, expected 0", o_win_cnt); end
    if (o_done) dones++;
    repeat (12) begin
      @(negedge clk); #1;
      if (o_done) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses, expected 0", dones); end
    run_frame(0, 1'b0);
    n_checks++; if (cap_pix != 64 || !cap_pix_ok || !cap_addr_ok) begin n_fail++; $display("FAIL abort_rerun_pixels: got %0d (data ok=%0b), expected 64 matching", cap_pix, cap_pix_ok); end
    n_checks++; if (cap_win !== 6'd36 || cap_done != 1 || cap_err_done !== 1'b0) begin n_fail++; $display("FAIL abort_rerun_result: got win=%0d done=%0d error=%0b, expected 36/1/0", cap_win, cap_done, cap_err_done); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i*7+3);
    clear = 1'b1; i_start = 1'b0; i_stall = 1'b0;
    test_reset();
    test_nominal();
    test_stall();
    test_hold_start();
    test_drain_timeout();
    test_dropped_window();
    test_clear_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
